square_wave_gen: RTL and testbench
==================================

# square_wave_gen

Parametrised square/PWM sample generator for the wave generator datapath. Replaces per-duty lookup tables with a phase accumulator and a duty comparator. Duty resolution, amplitude width and frequency are set at run time. Configuration goes through a valid/ready handshake and takes effect only on a period boundary, so the output never carries a glitched partial period. Output samples feed the same 16-bit sample bus as the other waveform sources.

## Interface
Parameters:
- DATA_W, 16, sample width
- PHASE_W, 10, phase accumulator width; one period spans 2^PHASE_W phase units

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst_n  in  1  reset, synchronous, active-low
- i_en  in  1  run enable; low forces the idle state
- i_cfg_valid  in  1  configuration offered
- o_cfg_ready  out  1  configuration can be accepted; equals ~pending
- i_ftw  in  PHASE_W  frequency tuning word, the phase increment per cycle
- i_duty  in  PHASE_W+1  high-time threshold in phase units; valid range 0..2^PHASE_W
- i_amp_hi  in  DATA_W  sample value during the high phase
- i_amp_lo  in  DATA_W  sample value during the low phase
- o_data  out  DATA_W  registered sample
- o_valid  out  1  o_data is a live sample
- o_wrap  out  1  one-cycle pulse marking the first sample of a period

## Operation
- States:
  - IDLE: phase is held at 0.
  - RUN: phase += active ftw (mod 2^PHASE_W) every cycle.
- State transitions:
  - IDLE→RUN: at the edge where i_en=1.
  - Any state→IDLE: at any edge where i_en=0.
- Configuration registers:
  - active: ftw, duty, amp_hi, amp_lo.
  - pending: one shadow copy plus a pending flag.
- Handshake: a transfer occurs on an edge with i_cfg_valid && o_cfg_ready.
  - In IDLE, or on the IDLE→RUN edge: the transfer loads active directly; pending stays 0.
  - In RUN: the transfer loads the shadow and sets pending.
- Period boundary: an edge in RUN where phase + ftw carries out of PHASE_W bits.
  - At that edge, phase takes the wrapped sum.
  - If pending=1, active loads from the shadow and pending clears.
  - A wrap flag register is set.
  - On the IDLE→RUN edge, phase is set to 0 and the wrap flag is set.
- Duty compare, using the current phase p and the active config:
  - Effective duty = min(duty, 2^PHASE_W).
  - Sample = amp_hi if p < effective duty, else amp_lo.
  - duty=0 gives constant lo; duty≥2^PHASE_W gives constant hi.
- ftw=0 in RUN: phase never advances and no wrap occurs, so pending is never applied and o_cfg_ready stays 0. The only exits are i_en=0 (pending is kept) or reset.
- A handshake on the same edge as a wrap is captured into the shadow and applied at the following wrap. The shadow is only accepted when pending=0, so the data being applied cannot be overwritten.
- Dropping i_en keeps both the active and the pending config. On the next IDLE→RUN edge, pending is applied, then cleared.

## Timing
- Reset (i_rst_n=0 at an edge), for all registers:
  - State IDLE, phase 0.
  - Active config all 0; shadow 0; pending 0 (so o_cfg_ready=1).
  - o_data=0, o_valid=0, o_wrap=0.
- Reset applies mid-run with no residual output on the next cycle.
- Output latency is 1 cycle from phase to sample:
  - o_data, o_valid and o_wrap register at each edge from the pre-edge phase, wrap flag and active config.
  - Edge k (i_en sampled 1 in IDLE): phase=0, wrap flag=1.
  - Edge k+1: o_valid=1, o_data=sample(0), o_wrap=1.
- Any edge with i_en=0: o_valid←0, o_data←0, o_wrap←0, phase←0.
- Config accepted in RUN at edge t: o_cfg_ready is 0 after edge t. At the first wrap edge w>t, the new config is active and o_cfg_ready returns to 1. The first sample using the new config appears at edge w+1, together with o_wrap=1.
- o_wrap is high for exactly one cycle per period; with ftw ≥ 2^(PHASE_W-1) it can be high on consecutive cycles.

## Test plan
- PHASE_W=10, ftw=64, duty=512, amp_hi=16'hFFFF, amp_lo=0; en rises → o_valid 1 cycle later, repeating 8×FFFF then 8×0000, o_wrap on each first FFFF, period 16.
- duty=0 → o_data constant amp_lo; duty=1024 and duty=2047 (clamped) → o_data constant amp_hi; o_wrap still every 16 cycles.
- Running with duty=512, offer duty=256 at cycle 5 of a period → current period stays 8 hi/8 lo, o_cfg_ready low until the wrap, next period 4 hi/12 lo; a second offer while pending is not accepted.
- ftw=100 for 1024 RUN cycles after start → exactly 100 o_wrap pulses (wrap+start); phase sequence 0,100,…,1000,76.
- ftw=0 in RUN with a pending config → o_cfg_ready stays 0; drop i_en, raise it again → pending applied, first sample uses the new config, o_cfg_ready=1.
- i_rst_n low for one edge mid-period → next cycle o_data=0, o_valid=0, o_cfg_ready=1, active config zeroed; i_en held high → RUN restarts at phase 0 with o_data=amp_lo=0.

Source files
------------

// File: rtl/square_wave_gen.sv
// square_wave_gen: square/PWM sample generator built from a phase accumulator
// and a duty comparator. New configurations are double-buffered so they only
// take effect on a period boundary and never produce a partial period.
module square_wave_gen #(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [PHASE_W-1:0] i_ftw,
  input  logic [PHASE_W:0]   i_duty,
  input  logic [DATA_W-1:0]  i_amp_hi,
  input  logic [DATA_W-1:0]  i_amp_lo,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid,
  output logic               o_wrap
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // One full period in phase units; duty values above this are clamped to it.
  localparam logic [PHASE_W:0] FULL_SCALE = {1'b1, {PHASE_W{1'b0}}};

  state_t state;
  state_t next_state;

  logic [PHASE_W-1:0] phase;
  logic               wrap_flag;

  logic [PHASE_W-1:0] act_ftw;
  logic [PHASE_W:0]   act_duty;
  logic [DATA_W-1:0]  act_hi;
  logic [DATA_W-1:0]  act_lo;

  logic [PHASE_W-1:0] sh_ftw;
  logic [PHASE_W:0]   sh_duty;
  logic [DATA_W-1:0]  sh_hi;
  logic [DATA_W-1:0]  sh_lo;
  logic               pending;

  logic [PHASE_W:0]   phase_sum;
  logic               carry;
  logic               cfg_fire;
  logic [PHASE_W:0]   eff_duty;
  logic [DATA_W-1:0]  sample;

  assign o_cfg_ready = ~pending;

  // Phase step, period-boundary detection and the duty compare for the current phase.
  always_comb begin
    phase_sum = {1'b0, phase} + {1'b0, act_ftw};
    carry     = phase_sum[PHASE_W];
    cfg_fire  = i_cfg_valid & ~pending;
    eff_duty  = (act_duty > FULL_SCALE) ? FULL_SCALE : act_duty;
    sample    = ({1'b0, phase} < eff_duty) ? act_hi : act_lo;
  end

  // State register; the enable alone decides between idling and running.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic: any edge with the enable low returns to IDLE.
  always_comb begin
    next_state = state;
    if (i_en) next_state = RUN;
    else      next_state = IDLE;
  end

  // Phase accumulator, wrap flag and the registered output sample.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phase     <= '0;
      wrap_flag <= 1'b0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_wrap    <= 1'b0;
    end else if (!i_en) begin
      phase     <= '0;
      wrap_flag <= 1'b0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_wrap    <= 1'b0;
    end else if (state == IDLE) begin
      phase     <= '0;
      wrap_flag <= 1'b1;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      phase     <= phase_sum[PHASE_W-1:0];
      wrap_flag <= carry;
      o_data    <= sample;
      o_valid   <= 1'b1;
      o_wrap    <= wrap_flag;
    end
  end

  // Active/shadow configuration: direct load while idle, deferred to the next wrap while running.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      act_ftw  <= '0;
      act_duty <= '0;
      act_hi   <= '0;
      act_lo   <= '0;
      sh_ftw   <= '0;
      sh_duty  <= '0;
      sh_hi    <= '0;
      sh_lo    <= '0;
      pending  <= 1'b0;
    end else if (state == IDLE) begin
      if (i_en && pending) begin
        act_ftw  <= sh_ftw;
        act_duty <= sh_duty;
        act_hi   <= sh_hi;
        act_lo   <= sh_lo;
        pending  <= 1'b0;
      end else if (cfg_fire) begin
        act_ftw  <= i_ftw;
        act_duty <= i_duty;
        act_hi   <= i_amp_hi;
        act_lo   <= i_amp_lo;
      end
    end else begin
      if (i_en && carry && pending) begin
        act_ftw  <= sh_ftw;
        act_duty <= sh_duty;
        act_hi   <= sh_hi;
        act_lo   <= sh_lo;
        pending  <= 1'b0;
      end
      if (cfg_fire) begin
        sh_ftw  <= i_ftw;
        sh_duty <= i_duty;
        sh_hi   <= i_amp_hi;
        sh_lo   <= i_amp_lo;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_square_wave_gen.sv
// Directed testbench for square_wave_gen with hand-computed expected samples.
module tb_square_wave_gen;

  localparam int DATA_W  = 16;
  localparam int PHASE_W = 10;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] ftw;
  logic [PHASE_W:0]   duty;
  logic [DATA_W-1:0]  amp_hi;
  logic [DATA_W-1:0]  amp_lo;
  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               wrap;

  int err_count;
  int check_count;

  square_wave_gen #(
    .DATA_W (DATA_W),
    .PHASE_W(PHASE_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_cfg_valid(cfg_valid),
    .o_cfg_ready(cfg_ready),
    .i_ftw      (ftw),
    .i_duty     (duty),
    .i_amp_hi   (amp_hi),
    .i_amp_lo   (amp_lo),
    .o_data     (data),
    .o_valid    (valid),
    .o_wrap     (wrap)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [PHASE_W-1:0] f, input logic [PHASE_W:0] d,
                               input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
    ftw    = f;
    duty   = d;
    amp_hi = hi;
    amp_lo = lo;
  endtask

  // Drop to IDLE, load a config directly, then take the IDLE->RUN edge.
  task automatic restartWith(input logic [PHASE_W-1:0] f, input logic [PHASE_W:0] d,
                             input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
    en        = 1'b0;
    cfg_valid = 1'b0;
    tick();
    tick();
    applyStimulus(f, d, hi, lo);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    en        = 1'b1;
    tick();
  endtask

  initial begin
    int wrap_count;
    int data_bad;
    int ph;
    logic [DATA_W-1:0] exp_data;
    logic              exp_wrap;
    logic [PHASE_W:0]  duty_list [3];

    err_count   = 0;
    check_count = 0;
    rst_n       = 1'b0;
    en          = 1'b0;
    cfg_valid   = 1'b0;
    applyStimulus('0, '0, '0, '0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_data", data, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_wrap", wrap, 0);
    checkOutput("rst_ready", cfg_ready, 1);
    rst_n = 1'b1;

    // Basic 50% square: 8 x FFFF then 8 x 0000, wrap on first FFFF
    restartWith(10'd64, 11'd512, 16'hFFFF, 16'h0000);
    checkOutput("start_valid_lat", valid, 0);
    checkOutput("start_ready", cfg_ready, 1);
    for (int n = 0; n < 32; n++) begin
      tick();
      checkOutput("sq_valid", valid, 1);
      checkOutput("sq_data", data, ((n % 16) < 8) ? 32'hFFFF : 32'h0);
      checkOutput("sq_wrap", wrap, ((n % 16) == 0) ? 1 : 0);
    end

    // Duty extremes: 0 gives constant lo, 1024 and 2047 give constant hi
    duty_list[0] = 11'd0;
    duty_list[1] = 11'd1024;
    duty_list[2] = 11'd2047;
    for (int k = 0; k < 3; k++) begin
      restartWith(10'd64, duty_list[k], 16'hA5A5, 16'h0F0F);
      for (int n = 0; n < 32; n++) begin
        tick();
        checkOutput("duty_ext_data", data, (k == 0) ? 32'h0F0F : 32'hA5A5);
        checkOutput("duty_ext_wrap", wrap, ((n % 16) == 0) ? 1 : 0);
      end
    end

    // Deferred config: duty 256 offered mid-period, second offer while pending ignored
    restartWith(10'd64, 11'd512, 16'hFFFF, 16'h0000);
    for (int n = 0; n < 32; n++) begin
      if (n == 5) begin
        applyStimulus(10'd64, 11'd256, 16'hFFFF, 16'h0000);
        cfg_valid = 1'b1;
      end
      if (n == 6) applyStimulus(10'd64, 11'd0, 16'hFFFF, 16'h0000);
      if (n == 8) cfg_valid = 1'b0;
      tick();
      checkOutput("defer_data", data, ((n % 16) < ((n < 16) ? 8 : 4)) ? 32'hFFFF : 32'h0);
      checkOutput("defer_wrap", wrap, ((n % 16) == 0) ? 1 : 0);
      checkOutput("defer_ready", cfg_ready, (n >= 5 && n < 15) ? 0 : 1);
    end

    // ftw=100: 100 wrap pulses over 1024 samples, phase 0,100,...,1000,76,...
    restartWith(10'd100, 11'd512, 16'hFFFF, 16'h0000);
    wrap_count = 0;
    data_bad   = 0;
    for (int n = 0; n < 1024; n++) begin
      tick();
      ph       = (n * 100) % 1024;
      exp_data = (ph < 512) ? 16'hFFFF : 16'h0000;
      exp_wrap = (n == 0) || (((n * 100) / 1024) != (((n - 1) * 100) / 1024));
      if (n < 16) begin
        checkOutput("ftw100_data", data, exp_data);
        checkOutput("ftw100_wrap", wrap, exp_wrap);
      end else if (data !== exp_data || wrap !== exp_wrap) begin
        data_bad++;
      end
      if (wrap === 1'b1) wrap_count++;
    end
    checkOutput("ftw100_wrap_count", wrap_count, 100);
    checkOutput("ftw100_late_errs", data_bad, 0);

    // ftw=0 in RUN: pending never applies until an IDLE->RUN restart
    restartWith(10'd0, 11'd1024, 16'h1234, 16'h0055);
    tick();
    checkOutput("ftw0_first_data", data, 32'h1234);
    checkOutput("ftw0_first_wrap", wrap, 1);
    tick();
    checkOutput("ftw0_wrap_once", wrap, 0);
    applyStimulus(10'd64, 11'd0, 16'hAAAA, 16'h5555);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checkOutput("ftw0_ready_low", cfg_ready, 0);
    for (int n = 0; n < 20; n++) begin
      tick();
      checkOutput("ftw0_hold_ready", cfg_ready, 0);
      checkOutput("ftw0_hold_wrap", wrap, 0);
      checkOutput("ftw0_hold_data", data, 32'h1234);
    end
    en = 1'b0;
    tick();
    checkOutput("ftw0_off_valid", valid, 0);
    checkOutput("ftw0_off_data", data, 0);
    checkOutput("ftw0_off_ready", cfg_ready, 0);
    tick();
    en = 1'b1;
    tick();
    checkOutput("ftw0_restart_ready", cfg_ready, 1);
    checkOutput("ftw0_restart_valid", valid, 0);
    tick();
    checkOutput("ftw0_new_valid", valid, 1);
    checkOutput("ftw0_new_data", data, 32'h5555);
    checkOutput("ftw0_new_wrap", wrap, 1);
    tick();
    checkOutput("ftw0_new_data2", data, 32'h5555);
    checkOutput("ftw0_new_wrap2", wrap, 0);

    // Reset mid-period with a pending config, enable held high
    restartWith(10'd64, 11'd256, 16'hBEEF, 16'h00F0);
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput("pre_rst_data", data, (n < 4) ? 32'hBEEF : 32'h00F0);
    end
    applyStimulus(10'd64, 11'd512, 16'h1111, 16'h2222);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checkOutput("pre_rst_ready", cfg_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mid_rst_data", data, 0);
    checkOutput("mid_rst_valid", valid, 0);
    checkOutput("mid_rst_wrap", wrap, 0);
    checkOutput("mid_rst_ready", cfg_ready, 1);
    tick();
    checkOutput("post_rst_valid_lat", valid, 0);
    tick();
    checkOutput("post_rst_valid", valid, 1);
    checkOutput("post_rst_data", data, 0);
    checkOutput("post_rst_wrap", wrap, 1);
    tick();
    checkOutput("post_rst_data2", data, 0);
    checkOutput("post_rst_wrap2", wrap, 0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
